// File: rtl/reg_file_mp_if.sv
// Register-file access bus: read ports, writeback, reserve and bulk-clear.
interface reg_file_mp_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_READ = 2
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [NUM_READ-1:0]        rd_en;
    logic [NUM_READ*ADDR_W-1:0] rd_addr;
    logic [NUM_READ*DATA_W-1:0] rd_data;
    logic [NUM_READ-1:0]        rd_busy;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [BE_W-1:0]            wr_be;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_addr;
    logic                       clr_req;
    logic                       clr_busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
               rsv_en, rsv_addr, clr_req,
        input  rd_data, rd_busy, clr_busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
               rsv_en, rsv_addr, clr_req,
        output rd_data, rd_busy, clr_busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-enable writes, write-to-read
// bypass, pending-write scoreboard and a one-register-per-cycle clear engine.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic           clock,
    input  logic           reset,
    reg_file_mp_if.slave   bus
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          idx_q, idx_d;
    logic                       clr_busy_q;

    logic [DATA_W-1:0]          mem [DEPTH];
    logic [DEPTH-1:0]           sb_q, sb_d;
    logic [NUM_READ*DATA_W-1:0] rd_data_q, rd_data_c;
    logic [NUM_READ-1:0]        rd_busy_q, rd_busy_c;
    logic                       wr_ok_c, rsv_ok_c;
    logic [DATA_W-1:0]          merged_c;

    // Address is backed by a real, writable register (not r0 when hardwired, not past DEPTH).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Clear FSM state, index and registered busy flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_busy_q <= (state_d == CLEAR);
        end
    end

    // Clear FSM next state: sweep idx from 0 to DEPTH-1, then return to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Post-write word, updated scoreboard and per-port read values (writes bypass into reads).
    always_comb begin
        wr_ok_c   = bus.wr_en  && (state_q == IDLE) && addr_ok(bus.wr_addr);
        rsv_ok_c  = bus.rsv_en && (state_q == IDLE) && addr_ok(bus.rsv_addr);
        merged_c  = mem[bus.wr_addr];
        sb_d      = sb_q;
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int b = 0; b < int'(BE_W); b++) begin
            if (bus.wr_be[b]) merged_c[b*8 +: 8] = bus.wr_data[b*8 +: 8];
        end
        if (wr_ok_c)  sb_d[bus.wr_addr]  = 1'b0;
        if (rsv_ok_c) sb_d[bus.rsv_addr] = 1'b1;
        for (int p = 0; p < int'(NUM_READ); p++) begin
            if (addr_ok(bus.rd_addr[p*ADDR_W +: ADDR_W])) begin
                if (wr_ok_c && (bus.rd_addr[p*ADDR_W +: ADDR_W] == bus.wr_addr))
                    rd_data_c[p*DATA_W +: DATA_W] = merged_c;
                else
                    rd_data_c[p*DATA_W +: DATA_W] = mem[bus.rd_addr[p*ADDR_W +: ADDR_W]];
                rd_busy_c[p] = sb_d[bus.rd_addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Storage, scoreboard and read-port registers; the clear sweep overrides writes at idx.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            sb_q      <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            if (wr_ok_c) mem[bus.wr_addr] <= merged_c;
            sb_q <= sb_d;
            if (state_q == CLEAR) begin
                mem[idx_q]  <= '0;
                sb_q[idx_q] <= 1'b0;
            end
            for (int p = 0; p < int'(NUM_READ); p++) begin
                if (bus.rd_en[p]) begin
                    rd_data_q[p*DATA_W +: DATA_W] <= rd_data_c[p*DATA_W +: DATA_W];
                    rd_busy_q[p]                  <= rd_busy_c[p];
                end
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.clr_busy = clr_busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed vector table, clear/reset sequences and
// random traffic checked against an array-based reference model.
module tb_reg_file_mp;
    localparam int unsigned DW = 32;
    localparam int unsigned DP = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_bad;

    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) bus ();

    reg_file_mp #(
        .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [31:0] m_mem [DP];
    bit          m_sb  [DP];
    int          clr_left;
    logic [31:0] exp_data [NR];
    bit          exp_busy [NR];
    bit          exp_clr;

    typedef struct {
        bit          wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_be;
        bit          rsv_en;
        logic [4:0]  rsv_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        bit          b0;
        bit          b1;
    } vec_t;

    vec_t tbl [8];

    function automatic bit m_ok(input int a);
        return (a < int'(DP)) && (a != 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [31:0] nm [DP];
        bit          ns [DP];
        logic [31:0] w;
        int          a;
        if (!reset) begin
            for (int i = 0; i < int'(DP); i++) begin
                m_mem[i] = '0;
                m_sb[i]  = 1'b0;
            end
            for (int p = 0; p < int'(NR); p++) begin
                exp_data[p] = '0;
                exp_busy[p] = 1'b0;
            end
            clr_left = 0;
            exp_clr  = 1'b0;
            return;
        end
        nm = m_mem;
        ns = m_sb;
        if (clr_left == 0 && bus.wr_en && m_ok(int'(bus.wr_addr))) begin
            w = m_mem[bus.wr_addr];
            for (int b = 0; b < 4; b++)
                if (bus.wr_be[b]) w[b*8 +: 8] = bus.wr_data[b*8 +: 8];
            nm[bus.wr_addr] = w;
            ns[bus.wr_addr] = 1'b0;
        end
        if (clr_left == 0 && bus.rsv_en && m_ok(int'(bus.rsv_addr)))
            ns[bus.rsv_addr] = 1'b1;
        for (int p = 0; p < int'(NR); p++) begin
            if (bus.rd_en[p]) begin
                a = int'(bus.rd_addr[p*AW +: AW]);
                exp_data[p] = m_ok(a) ? nm[a] : 32'h0;
                exp_busy[p] = m_ok(a) ? ns[a] : 1'b0;
            end
        end
        if (clr_left > 0) begin
            nm[int'(DP) - clr_left] = '0;
            ns[int'(DP) - clr_left] = 1'b0;
            clr_left--;
        end else if (bus.clr_req) begin
            clr_left = int'(DP);
        end
        m_mem   = nm;
        m_sb    = ns;
        exp_clr = (clr_left > 0);
    endtask

    // One clock: update model, let the edge pass, compare all outputs.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        for (int p = 0; p < int'(NR); p++) begin
            check($sformatf("model rd_data[%0d]", p), bus.rd_data[p*DW +: DW], exp_data[p]);
            check($sformatf("model rd_busy[%0d]", p), 32'(bus.rd_busy[p]), 32'(exp_busy[p]));
        end
        check("model clr_busy", 32'(bus.clr_busy), 32'(exp_clr));
    endtask

    task automatic idle_inputs();
        bus.rd_en   = '0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_be   = '0;
        bus.rsv_en  = 1'b0;
        bus.rsv_addr= '0;
        bus.clr_req = 1'b0;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = 4'hF;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Read every register pairwise and expect zero data, zero busy.
    task automatic expect_all_zero(input string tag);
        bus.wr_en = 1'b0; bus.rsv_en = 1'b0; bus.clr_req = 1'b0;
        bus.rd_en = 2'b11;
        for (int r = 0; r < int'(DP); r += 2) begin
            bus.rd_addr = {5'(r + 1), 5'(r)};
            tick();
            check($sformatf("%s r%0d", tag, r),     bus.rd_data[31:0],  32'h0);
            check($sformatf("%s r%0d", tag, r + 1), bus.rd_data[63:32], 32'h0);
            check($sformatf("%s busy r%0d", tag, r), 32'(bus.rd_busy), 32'h0);
        end
        bus.rd_en = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        n_vec = 0;
        n_bad = 0;
        clr_left = 0;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Reset state
        check("reset rd_data", bus.rd_data[31:0], 32'h0);
        check("reset clr_busy", 32'(bus.clr_busy), 32'h0);

        // T1: reset clears a written register
        write(5'd5, 32'hDEADBEEF);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.rd_en = 2'b01; bus.rd_addr = {5'd0, 5'd5};
        tick();
        check("T1 r5 data", bus.rd_data[31:0], 32'h0);
        check("T1 r5 busy", 32'(bus.rd_busy[0]), 32'h0);
        check("T1 clr_busy", 32'(bus.clr_busy), 32'h0);

        // Directed table: bypass, byte enables, zero register, scoreboard
        tbl[0] = '{1, 5'd7,  32'h11223344, 4'hF, 0, 5'd0, 5'd7,  5'd0,  32'h11223344, 32'h0,        0, 0};
        tbl[1] = '{1, 5'd7,  32'hAAAABBBB, 4'h3, 0, 5'd0, 5'd7,  5'd7,  32'h1122BBBB, 32'h1122BBBB, 0, 0};
        tbl[2] = '{1, 5'd0,  32'hFFFFFFFF, 4'hF, 1, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        0, 0};
        tbl[3] = '{0, 5'd0,  32'h0,        4'h0, 1, 5'd3, 5'd3,  5'd7,  32'h0,        32'h1122BBBB, 1, 0};
        tbl[4] = '{1, 5'd3,  32'h000000AB, 4'h1, 0, 5'd0, 5'd3,  5'd3,  32'h000000AB, 32'h000000AB, 0, 0};
        tbl[5] = '{1, 5'd3,  32'h00005500, 4'h2, 1, 5'd3, 5'd3,  5'd3,  32'h000055AB, 32'h000055AB, 1, 1};
        tbl[6] = '{1, 5'd31, 32'hCAFEF00D, 4'hA, 0, 5'd0, 5'd31, 5'd3,  32'hCA00F000, 32'h000055AB, 0, 1};
        tbl[7] = '{1, 5'd3,  32'h12345678, 4'h0, 0, 5'd0, 5'd3,  5'd31, 32'h000055AB, 32'hCA00F000, 0, 0};
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = tbl[i].wr_en; bus.wr_addr = tbl[i].wr_addr;
            bus.wr_data = tbl[i].wr_data; bus.wr_be = tbl[i].wr_be;
            bus.rsv_en = tbl[i].rsv_en; bus.rsv_addr = tbl[i].rsv_addr;
            bus.rd_en = 2'b11; bus.rd_addr = {tbl[i].ra1, tbl[i].ra0};
            tick();
            check($sformatf("vec%0d p0 data", i), bus.rd_data[31:0],  tbl[i].e0);
            check($sformatf("vec%0d p1 data", i), bus.rd_data[63:32], tbl[i].e1);
            check($sformatf("vec%0d p0 busy", i), 32'(bus.rd_busy[0]), 32'(tbl[i].b0));
            check($sformatf("vec%0d p1 busy", i), 32'(bus.rd_busy[1]), 32'(tbl[i].b1));
        end
        idle_inputs();

        // T5: fill, clear, writes dropped during the sweep
        for (int r = 1; r < int'(DP); r++) write(5'(r), 32'h1000_0000 + 32'(r) * 32'h0101);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        cnt = bus.clr_busy ? 1 : 0;
        for (int k = 0; k < 40 && bus.clr_busy; k++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'hFFFFFFFF; bus.wr_be = 4'hF;
            bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4; bus.clr_req = 1'b1;
            bus.rd_en = 2'b11; bus.rd_addr = {5'($urandom_range(31)), 5'($urandom_range(31))};
            tick();
            if (bus.clr_busy) cnt++;
        end
        check("T5 clr_busy cycles", 32'(cnt), 32'd32);
        expect_all_zero("T5 after clear");

        // T6: reset in the middle of a clear
        for (int r = 1; r < 13; r++) write(5'(r), 32'hA5A5_0000 | 32'(r));
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("T6 clr_busy before reset", 32'(bus.clr_busy), 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("T6 clr_busy after reset", 32'(bus.clr_busy), 32'h0);
        expect_all_zero("T6 after reset");

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            bus.wr_en    = ($urandom_range(99) < 60);
            bus.wr_addr  = 5'($urandom_range(31));
            bus.wr_data  = $urandom;
            bus.wr_be    = 4'($urandom_range(15));
            bus.rsv_en   = ($urandom_range(99) < 30);
            bus.rsv_addr = ($urandom_range(3) == 0) ? bus.wr_addr : 5'($urandom_range(31));
            bus.clr_req  = ($urandom_range(99) < 2);
            bus.rd_en    = 2'($urandom_range(3));
            for (int p = 0; p < int'(NR); p++)
                bus.rd_addr[p*AW +: AW] = ($urandom_range(3) == 0) ? bus.wr_addr : 5'($urandom_range(31));
            reset = ($urandom_range(199) != 0);
            tick();
            reset = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
